gate_bist: RTL



---
 rtl/gate_bist.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/gate_bist.sv
// gate_bist
//
// Stimulus/response checker for a 2-input combinational gate primitive.
// It walks the gate inputs through {b,a} = 0,1,2,3, holds each vector for
// SETTLE_CYCLES cycles, then samples the gate output and compares it with
// TRUTH[{b,a}]. The results are pass, err_count and fail_idx. They stay valid
// after the done pulse until the next run is accepted.
//
// Parameters:
//   TRUTH          expected gate output per vector, bit index {b,a} (default OR)
//   SETTLE_CYCLES  cycles each vector is held before it is sampled (1..15)
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   start      in   begin a run (only looked at in IDLE)
//   dut_out    in   output of the gate under test (not synchronised)
//   dut_a      out  gate input a (idx[0])
//   dut_b      out  gate input b (idx[1])
//   busy       out  high from the accepting edge until DONE is left
//   done       out  one-cycle pulse when a run completes
//   pass       out  last completed run had zero mismatches
//   err_count  out  number of mismatches in the last run (0..4)
//   fail_idx   out  {b,a} of the first mismatching vector, 0 if none
//
// Build option:
//   GATE_BIST_STOP_ON_FAIL_EN  when defined, the first mismatch ends the run
//                              immediately and the remaining vectors are skipped.
module gate_bist #(
    parameter logic [3:0] TRUTH         = 4'b1110,
    parameter int         SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       dut_out,
    output logic       dut_a,
    output logic       dut_b,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count,
    output logic [1:0] fail_idx
);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        DONE
    } state_t;

`ifdef GATE_BIST_STOP_ON_FAIL_EN
    localparam bit STOP_ON_FAIL = 1'b1;
`else
    localparam bit STOP_ON_FAIL = 1'b0;
`endif

    // The counter is loaded with S-1 and SETTLE exits when it reaches 0.
    // This gives S cycles of SETTLE before the SAMPLE cycle.
    localparam logic [3:0] SETTLE_RELOAD = 4'(SETTLE_CYCLES - 1);

    state_t     state;
    logic [1:0] idx;
    logic [3:0] settle_cnt;

    logic       mismatch;
    logic [1:0] idx_next;
    logic       last_vector;

    assign mismatch    = (dut_out != TRUTH[idx]);
    assign idx_next    = idx + 2'd1;
    assign last_vector = (idx == 2'd3) || (STOP_ON_FAIL && mismatch);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            idx        <= 2'd0;
            settle_cnt <= 4'd0;
            dut_a      <= 1'b0;
            dut_b      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= 3'd0;
            fail_idx   <= 2'd0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= SETTLE;
                        idx        <= 2'd0;
                        settle_cnt <= SETTLE_RELOAD;
                        dut_a      <= 1'b0;
                        dut_b      <= 1'b0;
                        busy       <= 1'b1;
                        pass       <= 1'b0;
                        err_count  <= 3'd0;
                        fail_idx   <= 2'd0;
                    end
                end

                SETTLE: begin
                    if (settle_cnt == 4'd0) begin
                        state <= SAMPLE;
                    end else begin
                        settle_cnt <= settle_cnt - 4'd1;
                    end
                end

                SAMPLE: begin
                    if (mismatch) begin
                        // Only four samples occur per run, so this cannot pass 4.
                        err_count <= err_count + 3'd1;
                        if (err_count == 3'd0) begin
                            fail_idx <= idx;
                        end
                    end
                    if (last_vector) begin
                        state <= DONE;
                        done  <= 1'b1;
                        pass  <= (err_count == 3'd0) && !mismatch;
                        dut_a <= 1'b0;
                        dut_b <= 1'b0;
                    end else begin
                        state      <= SETTLE;
                        idx        <= idx_next;
                        settle_cnt <= SETTLE_RELOAD;
                        dut_a      <= idx_next[0];
                        dut_b      <= idx_next[1];
                    end
                end

                DONE: begin
                    // A start that arrives in this cycle is not seen. The
                    // earliest restart is the next IDLE cycle.
                    state <= IDLE;
                    busy  <= 1'b0;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
